bus_cycle_gen: RTL and testbench

Bus cycle generator sitting directly upstream of the I/O / memory device on the system bus. It accepts single-byte read/write requests from the CPU core over a valid/ready handshake. It converts each request into a T1–T4 bus cycle (ALE, address, IOM, RD_N/WR_N, data), inserting wait states while READY is low. It returns read data, or a timeout error, to the core.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_wait_timer.sv | 27 ++
 rtl/bus_cycle_gen.sv | 144 ++++++++++++++
 tb/tb_bus_cycle_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and widths for the bus cycle generator
package bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } bus_state_e;

    typedef struct packed {
        logic              write;
        logic              io;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // States in which the read or write strobe is held active.
    function automatic logic strobe_state(input bus_state_e s);
        return (s == T2) || (s == T3) || (s == TW);
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - wait-state counter with timeout compare
module bus_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic advance,
    output logic timeout
);

    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

    logic [7:0] count;

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 8'd1;
        end
    end

    // Asserted during the wait state whose increment would reach MAX_WAIT.
    assign timeout = (count == LAST);

endmodule

// File: rtl/bus_cycle_gen.sv
// rtl/bus_cycle_gen.sv - converts core byte requests into T1-T4 bus cycles
module bus_cycle_gen
    import bus_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_io,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ALE,
    output logic [ADDR_W-1:0] Address,
    output logic              IOM,
    output logic              RD_N,
    output logic              WR_N,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_OE,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              READY
);

    bus_state_e state_q;
    bus_state_e state_d;
    bus_req_t   req_q;

    logic load;
    logic timer_clr;
    logic timer_inc;
    logic timeout;
    logic err_d;
    logic write_sel;
    logic strobe_d;
    logic capture;

    bus_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (timer_clr),
        .advance(timer_inc),
        .timeout(timeout)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = T1;
                end
            end
            T1: state_d = T2;
            T2: state_d = T3;
            T3: begin
                if (READY) begin
                    state_d = T4;
                end else begin
                    timer_clr = 1'b1;
                    state_d   = TW;
                end
            end
            TW: begin
                timer_inc = 1'b1;
                if (READY) begin
                    state_d = T4;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = T4;
                end
            end
            T4: begin
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = T1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign write_sel = load ? req_write : req_q.write;
    assign strobe_d  = strobe_state(state_d);
    assign capture   = ((state_q == T3) || (state_q == TW)) && (state_d == T4);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ALE       <= 1'b0;
            RD_N      <= 1'b1;
            WR_N      <= 1'b1;
            DATA_OE   <= 1'b0;
            DATA_OUT  <= '0;
        end else begin
            req_ready <= (state_d == IDLE) || (state_d == T4);
            rsp_valid <= (state_d == T4);
            ALE       <= (state_d == T1);
            RD_N      <= !(strobe_d && !write_sel);
            WR_N      <= !(strobe_d && write_sel);
            DATA_OE   <= strobe_d && write_sel;
            if (load) begin
                req_q <= '{write: req_write, io: req_io, addr: req_addr, wdata: req_wdata};
            end
            if ((state_q == T1) && req_q.write) begin
                DATA_OUT <= req_q.wdata;
            end
            if (capture) begin
                rsp_err   <= err_d;
                rsp_rdata <= (!req_q.write && !err_d) ? DATA_IN : '0;
            end
        end
    end

    assign Address = req_q.addr;
    assign IOM     = req_q.io;

endmodule

// File: tb/tb_bus_cycle_gen.sv
// tb/tb_bus_cycle_gen.sv - randomized self-checking bench for bus_cycle_gen
module tb_bus_cycle_gen;

    localparam int MW = 15;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        ALE;
    logic [19:0] Address;
    logic        IOM;
    logic        RD_N;
    logic        WR_N;
    logic [7:0]  DATA_OUT;
    logic        DATA_OE;
    logic [7:0]  DATA_IN;
    logic        READY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ale = 0;

    bus_cycle_gen #(.MAX_WAIT(MW)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_io   (req_io),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .ALE      (ALE),
        .Address  (Address),
        .IOM      (IOM),
        .RD_N     (RD_N),
        .WR_N     (WR_N),
        .DATA_OUT (DATA_OUT),
        .DATA_OE  (DATA_OE),
        .DATA_IN  (DATA_IN),
        .READY    (READY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // One transaction, presented at the current negedge. READY is low for n
    // clocks starting at T3, then high; outside T3/TW it is random noise.
    // Model: waits = min(n, MW), rsp at clock 4 + waits, error when n > MW.
    task automatic run_txn(input logic w, input logic io, input logic [19:0] a,
                           input logic [7:0] wd, input int n, input logic keep_valid);
        int   waits;
        int   lat;
        logic exp_err;
        logic exp_act;
        logic [7:0] exp_rd;
        waits   = (n <= MW) ? n : MW;
        lat     = 4 + waits;
        exp_err = (n > MW);
        exp_rd  = 8'h00;
        req_valid = 1'b1;
        req_write = w;
        req_io    = io;
        req_addr  = a;
        req_wdata = wd;
        READY     = 1'($urandom);
        DATA_IN   = 8'($urandom);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL txn_ready_at_handshake got %b expected 1", req_ready);
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge CLK);
            exp_act = (c >= 2) && (c <= lat - 1);
            if (c == 1) last_ale = cyc;
            checks++;
            if (ALE !== (c == 1)) begin
                errors++;
                $display("FAIL ale clk %0d got %b expected %b", c, ALE, (c == 1));
            end
            checks++;
            if (RD_N !== !(exp_act && !w)) begin
                errors++;
                $display("FAIL rd_n clk %0d got %b expected %b", c, RD_N, !(exp_act && !w));
            end
            checks++;
            if (WR_N !== !(exp_act && w)) begin
                errors++;
                $display("FAIL wr_n clk %0d got %b expected %b", c, WR_N, !(exp_act && w));
            end
            checks++;
            if (DATA_OE !== (exp_act && w)) begin
                errors++;
                $display("FAIL data_oe clk %0d got %b expected %b", c, DATA_OE, (exp_act && w));
            end
            if (exp_act && w) begin
                checks++;
                if (DATA_OUT !== wd) begin
                    errors++;
                    $display("FAIL data_out clk %0d got %h expected %h", c, DATA_OUT, wd);
                end
            end
            checks++;
            if (Address !== a || IOM !== io) begin
                errors++;
                $display("FAIL addr_iom clk %0d got %h/%b expected %h/%b", c, Address, IOM, a, io);
            end
            checks++;
            if (rsp_valid !== (c == lat)) begin
                errors++;
                $display("FAIL rsp_valid clk %0d got %b expected %b", c, rsp_valid, (c == lat));
            end
            if (c == lat) begin
                checks++;
                if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
                    errors++;
                    $display("FAIL rsp_data_err got %h/%b expected %h/%b", rsp_rdata, rsp_err, exp_rd, exp_err);
                end
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_in_t4 got %b expected 1", req_ready);
                end
            end
            if (c < lat) begin
                if (!keep_valid) req_valid = 1'b0;
                req_write = 1'($urandom);
                req_io    = 1'($urandom);
                req_addr  = 20'($urandom);
                req_wdata = 8'($urandom);
            end
            DATA_IN = 8'($urandom);
            if (c >= 3 && c < 3 + n)  READY = 1'b0;
            else if (c == 3 + n)      READY = 1'b1;
            else                      READY = 1'($urandom);
            if (c == 3 + waits && !w && !exp_err) exp_rd = DATA_IN;
        end
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || RD_N !== 1'b1 || WR_N !== 1'b1) begin
            errors++;
            $display("FAIL idle got valid=%b ready=%b rd_n=%b wr_n=%b", rsp_valid, req_ready, RD_N, WR_N);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp got %b %b %h %b expected 1 0 00 0", req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        if (ALE !== 1'b0 || RD_N !== 1'b1 || WR_N !== 1'b1 || DATA_OE !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus got %b %b %b %b expected 0 1 1 0", ALE, RD_N, WR_N, DATA_OE);
        end
        checks++;
        if (Address !== 20'h0 || IOM !== 1'b0 || DATA_OUT !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr got %h %b %h expected 0 0 0", Address, IOM, DATA_OUT);
        end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_read();
        logic [7:0] saved;
        run_txn(1'b0, 1'b1, 20'h0_1234, 8'h00, 0, 1'b0);
        saved = rsp_rdata;
        idle_cycle();
        checks++;
        if (rsp_rdata !== saved) begin
            errors++;
            $display("FAIL rdata_hold got %h expected %h", rsp_rdata, saved);
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 1'b0, 20'hF_FFFF, 8'h3C, 0, 1'b0);
        idle_cycle();
        checks++;
        if (DATA_OUT !== 8'h3C) begin
            errors++;
            $display("FAIL data_out_hold got %h expected 3c", DATA_OUT);
        end
    endtask

    task automatic test_wait();
        run_txn(1'b0, 1'b0, 20'h5_5AA5, 8'h00, 3, 1'b0);
        idle_cycle();
        run_txn(1'b1, 1'b1, 20'h0_0001, 8'h81, 1, 1'b0);
        idle_cycle();
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b0, 20'hA_BCDE, 8'h00, MW, 1'b0);
        idle_cycle();
        run_txn(1'b0, 1'b1, 20'h1_2345, 8'h00, MW + 1, 1'b0);
        idle_cycle();
        run_txn(1'b1, 1'b0, 20'h0_0F0F, 8'h77, MW + 4, 1'b0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int first_ale;
        run_txn(1'b0, 1'b1, 20'h0_1000, 8'h00, 0, 1'b1);
        first_ale = last_ale;
        run_txn(1'b1, 1'b0, 20'h0_2000, 8'h5A, 0, 1'b1);
        checks++;
        if (last_ale - first_ale !== 4) begin
            errors++;
            $display("FAIL b2b_ale_spacing got %0d expected 4", last_ale - first_ale);
        end
        run_txn(1'b0, 1'b0, 20'h0_3000, 8'h00, 2, 1'b0);
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_io    = 1'b1;
        req_addr  = 20'h4_4444;
        req_wdata = 8'h00;
        READY     = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            READY     = 1'b0;
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++;
        if (RD_N !== 1'b1 || WR_N !== 1'b1 || ALE !== 1'b0 || DATA_OE !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_strobes got %b %b %b %b expected 1 1 0 0", RD_N, WR_N, ALE, DATA_OE);
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            READY = 1'b1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_rsp clk %0d got %b expected 0", i, rsp_valid);
            end
        end
        run_txn(1'b0, 1'b0, 20'h0_0ABC, 8'h00, 2, 1'b0);
        idle_cycle();
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            run_txn(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom),
                    int'($urandom_range(MW + 3, 0)), 1'($urandom_range(1, 0)));
            if ($urandom_range(2, 0) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        RESET     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_io    = 1'b0;
        req_addr  = 20'h0;
        req_wdata = 8'h00;
        DATA_IN   = 8'h00;
        READY     = 1'b1;
        @(negedge CLK);
        test_reset();
        test_read();
        test_write();
        test_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
